// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg: SimpleRISC opcodes, instruction field positions, hazard FSM state and control bundle
package simplerisc_pkg;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;
  localparam int OP_LSB  = 27;
  localparam int I_BIT   = 26;
  localparam int RD_LSB  = 22;
  localparam int RS1_LSB = 18;
  localparam int RS2_LSB = 14;
  localparam logic [3:0] RA_IDX = 4'hF;
  typedef enum logic {RUN, MC_WAIT} state_t;
  typedef struct packed {
    logic pc_stall;
    logic if_of_stall;
    logic if_of_flush;
    logic of_ex_bubble;
    logic of_ex_stall;
    logic ex_ma_bubble;
    logic mc_busy;
  } ctrl_t;
  localparam ctrl_t C_MC    = 7'b1100110;
  localparam ctrl_t C_LU    = 7'b1101000;
  localparam ctrl_t C_FLUSH = 7'b0011000;
  localparam ctrl_t C_BUSY  = 7'b0000001;
endpackage

// File: rtl/simplerisc_src_decode.sv
// simplerisc_src_decode: source-register extraction for one instruction, shared with the forwarding units
module simplerisc_src_decode
  import simplerisc_pkg::*;
(
  input  logic [31:0] ir,
  output logic [3:0]  src1,
  output logic        src1_valid,
  output logic [3:0]  src2,
  output logic        src2_valid,
  output logic [3:0]  st_src,
  output logic        st_valid
);
  logic [4:0] op;
  logic       ctl_flow;
  logic       unused_imm;
  assign op         = ir[OP_LSB +: 5];
  assign ctl_flow   = op inside {OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_RET};
  assign src1       = op == OP_RET ? RA_IDX : ir[RS1_LSB +: 4];
  assign src1_valid = !(op inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_NOT, OP_MOV});
  assign src2       = ir[RS2_LSB +: 4];
  assign src2_valid = !ir[I_BIT] && !ctl_flow && !(op inside {OP_NOP, OP_LD});
  assign st_src     = ir[RD_LSB +: 4];
  assign st_valid   = op == OP_ST;
  assign unused_imm = ^ir[13:0];
endmodule

// File: rtl/pipeline_interlock_ctrl.sv
// pipeline_interlock_ctrl: load-use / branch-flush / div-mod interlock for the 5-stage pipeline
// Optional perf counters built only when INTERLOCK_PERF_CNT_EN is defined.
module pipeline_interlock_ctrl
  import simplerisc_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] of_ir,
  input  logic        of_valid,
  input  logic [31:0] ex_ir,
  input  logic        ex_valid,
  input  logic        ex_branch_taken,
  output logic        pc_stall,
  output logic        if_of_stall,
  output logic        if_of_flush,
  output logic        of_ex_bubble,
  output logic        of_ex_stall,
  output logic        ex_ma_bubble,
  output logic        mc_busy,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
);
  localparam logic [CNT_W-1:0] MC_INIT = CNT_W'(MC_LAT - 2);
  state_t     state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  ctrl_t      ctrl;
  logic [3:0] src1, src2, st_src;
  logic       src1_valid, src2_valid, st_valid;
  logic [4:0] ex_op;
  logic [3:0] ex_rd;
  logic       lu_haz;
  logic       unused_ex;
  simplerisc_src_decode u_of_dec (
    .ir(of_ir), .src1(src1), .src1_valid(src1_valid), .src2(src2), .src2_valid(src2_valid),
    .st_src(st_src), .st_valid(st_valid)
  );
  assign ex_op     = ex_ir[OP_LSB +: 5];
  assign ex_rd     = ex_ir[RD_LSB +: 4];
  assign unused_ex = ^{ex_ir[I_BIT], ex_ir[RS1_LSB +: 4], ex_ir[17:0]};
  assign lu_haz    = ex_valid && of_valid && ex_op == OP_LD &&
                     ((src1_valid && src1 == ex_rd) || (src2_valid && src2 == ex_rd) ||
                      (st_valid && st_src == ex_rd));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ctrl     = '0;
    if (state == MC_WAIT) begin
      ctrl     = cnt != '0 ? C_MC | C_BUSY : C_BUSY;
      cnt_nx   = cnt != '0 ? cnt - 1'b1 : cnt;
      state_nx = cnt != '0 ? MC_WAIT : RUN;
    end else if (ex_valid && ex_branch_taken)
      ctrl = C_FLUSH;
    else if (ex_valid && ex_op inside {OP_DIV, OP_MOD}) begin
      ctrl     = C_MC;
      cnt_nx   = MC_INIT;
      state_nx = MC_WAIT;
    end else if (lu_haz)
      ctrl = C_LU;
  end
  // Gated by rst_n so a held div or taken branch cannot leak through during reset.
  assign {pc_stall, if_of_stall, if_of_flush, of_ex_bubble, of_ex_stall, ex_ma_bubble, mc_busy} =
    rst_n ? ctrl : '0;
`ifdef INTERLOCK_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (if_of_flush && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule
